// File: rtl/systemverilog_bus_demux_if.sv
// Stream-side and bus-side signals of the byte-stream to bus deserializer.
interface systemverilog_bus_demux_if;
  logic        str_vld;
  logic [7:0]  str_bus;
  logic        str_rdy;
  logic        bus_vld;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
  logic        bus_rdy;

  // Deserializer view: consumes the stream, initiates bus transfers.
  modport slave (
    input  str_vld, str_bus, bus_rdy,
    output str_rdy, bus_vld, bus_adr, bus_dat
  );

  // Environment view: produces the stream, acknowledges bus transfers.
  modport master (
    output str_vld, str_bus, bus_rdy,
    input  str_rdy, bus_vld, bus_adr, bus_dat
  );
endinterface

// File: rtl/systemverilog_bus_demux.sv
// Byte-stream to bus deserializer: 8 stream bytes form one {adr, dat} packet,
// bytes 0-3 are dat LSB first, bytes 4-7 are adr LSB first. One assembled
// packet is held on the bus while the next one keeps assembling.
module systemverilog_bus_demux (
  input  logic                      clk,
  input  logic                      rst,
  systemverilog_bus_demux_if.slave  io
);

  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  asm_q [7];
  logic [7:0]  asm_d [7];
  logic        bus_vld_q, bus_vld_d;
  logic [31:0] bus_adr_q, bus_adr_d;
  logic [31:0] bus_dat_q, bus_dat_d;

  logic        str_rdy;
  logic        str_trn;
  logic        bus_trn;
  logic        pkt_done;

  // Handshake: only the final byte has to wait for a free output slot.
  always_comb begin
    str_rdy  = ~rst & ~((cnt_q == 3'd7) & bus_vld_q & ~io.bus_rdy);
    str_trn  = io.str_vld & str_rdy;
    bus_trn  = bus_vld_q & io.bus_rdy;
    pkt_done = str_trn & (cnt_q == 3'd7);
  end

  // Next state: byte collection, packet hand-over and bus valid tracking.
  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    bus_vld_d = bus_vld_q;
    bus_adr_d = bus_adr_q;
    bus_dat_d = bus_dat_q;

    if (str_trn) begin
      cnt_d = cnt_q + 3'd1;
    end

    for (int unsigned i = 0; i < 7; i++) begin
      if (str_trn && (cnt_q == 3'(i))) begin
        asm_d[i] = io.str_bus;
      end
    end

    // Completion wins over retirement so a simultaneous retire/load keeps valid high.
    if (pkt_done) begin
      bus_dat_d = {asm_q[3], asm_q[2], asm_q[1], asm_q[0]};
      bus_adr_d = {io.str_bus, asm_q[6], asm_q[5], asm_q[4]};
      bus_vld_d = 1'b1;
    end else if (bus_trn) begin
      bus_vld_d = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_vld_q <= 1'b0;
      bus_adr_q <= '0;
      bus_dat_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bus_vld_q <= bus_vld_d;
      bus_adr_q <= bus_adr_d;
      bus_dat_q <= bus_dat_d;
    end
  end

  // Assembly bytes carry no reset; they are always written before being used.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign io.str_rdy = str_rdy;
  assign io.bus_vld = bus_vld_q;
  assign io.bus_adr = bus_adr_q;
  assign io.bus_dat = bus_dat_q;

endmodule

// File: tb/tb_systemverilog_bus_demux.sv
// Testbench for systemverilog_bus_demux: directed packets, bus stalls,
// stream gaps and resets, with a queue-based packet checker.
module tb_systemverilog_bus_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systemverilog_bus_demux_if bif ();

  systemverilog_bus_demux dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [63:0] exp_q [$];
  int          b7_cyc = -1;
  bit          b7_pend = 1'b0;
  int          trn_cnt = 0;
  int          last_trn_cyc = 0;
  int          prev_trn_cyc = 0;
  int          stall_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet checker: compares the presented packet against the queue head every
  // cycle it is valid, retires it on acknowledge, and checks one-cycle latency.
  always @(negedge clk) begin
    if (b7_pend && cyc == b7_cyc) begin
      chk("latency_vld", 64'(bif.bus_vld), 64'd1);
      b7_pend = 1'b0;
    end
    if (!rst && bif.bus_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pkt: got adr %h dat %h expected no packet", bif.bus_adr, bif.bus_dat);
      end else begin
        chk("pkt", {bif.bus_adr, bif.bus_dat}, exp_q[0]);
        if (bif.bus_rdy) begin
          void'(exp_q.pop_front());
          trn_cnt++;
          prev_trn_cyc = last_trn_cyc;
          last_trn_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit ok;
    ok = 1'b0;
    bif.str_vld = 1'b1;
    bif.str_bus = b;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      ok = bif.str_rdy;
      if (!ok) stall_cnt++;
      tick();
    end
    if (!ok) chk("str_accept_timeout", 64'd0, 64'd1);
    else if (last) begin
      b7_cyc  = cyc;
      b7_pend = 1'b1;
    end
    bif.str_vld = 1'b0;
    bif.str_bus = 8'hA5;
  endtask

  task automatic send_pkt(input logic [31:0] adr, input logic [31:0] dat, input int gap);
    logic [63:0] v;
    v = {adr, dat};
    exp_q.push_back(v);
    for (int k = 0; k < 8; k++) begin
      send_byte(v[8*k +: 8], k == 7);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_cnt", 64'(dut.cnt_q), 64'((k + 1) % 8));
        tick();
      end
    end
  endtask

  initial begin
    logic [7:0]  basic_bytes [8];
    logic [63:0] v2;
    int          t0;
    int          s0;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  basic_bytes [8];
    logic [63:0] v2;
    int          t0;
    int          s0;

    rst         = 1'b1;
    bif.str_vld = 1'b0;
    bif.str_bus = 8'h00;
    bif.bus_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_str_rdy", 64'(bif.str_rdy), 64'd0);
    chk("rst_bus_vld", 64'(bif.bus_vld), 64'd0);
    chk("rst_bus_adr", 64'(bif.bus_adr), 64'd0);
    chk("rst_bus_dat", 64'(bif.bus_dat), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_str_rdy", 64'(bif.str_rdy), 64'd1);
    chk("post_rst_cnt", 64'(dut.cnt_q), 64'd0);
    tick();

    // Basic packet from hand-listed bytes.
    basic_bytes = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    t0 = trn_cnt;
    s0 = stall_cnt;
    exp_q.push_back(64'h89ABCDEF_01234567);
    for (int k = 0; k < 8; k++) send_byte(basic_bytes[k], k == 7);
    tick();
    @(negedge clk);
    chk("basic_vld_low", 64'(bif.bus_vld), 64'd0);
    tick();
    chk("basic_trn_cnt", 64'(trn_cnt - t0), 64'd1);
    chk("basic_no_stall", 64'(stall_cnt - s0), 64'd0);

    // Back-to-back packets.
    t0 = trn_cnt;
    s0 = stall_cnt;
    send_pkt(32'h11111111, 32'h22222222, 0);
    send_pkt(32'h33333333, 32'h44444444, 0);
    tick();
    tick();
    chk("b2b_trn_cnt", 64'(trn_cnt - t0), 64'd2);
    chk("b2b_spacing", 64'(last_trn_cyc - prev_trn_cyc), 64'd8);
    chk("b2b_no_stall", 64'(stall_cnt - s0), 64'd0);

    // Bus stall while the next packet streams in.
    bif.bus_rdy = 1'b0;
    send_pkt(32'hDEADBEEF, 32'hCAFEF00D, 0);
    s0 = stall_cnt;
    v2 = {32'h12345678, 32'h9ABCDEF0};
    exp_q.push_back(v2);
    for (int k = 0; k < 7; k++) send_byte(v2[8*k +: 8], 1'b0);
    chk("stall_bytes06_accepted", 64'(stall_cnt - s0), 64'd0);
    bif.str_vld = 1'b1;
    bif.str_bus = v2[63:56];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_str_rdy_low", 64'(bif.str_rdy), 64'd0);
      chk("stall_cnt7", 64'(dut.cnt_q), 64'd7);
      tick();
    end
    bif.bus_rdy = 1'b1;
    @(negedge clk);
    chk("stall_release_str_rdy", 64'(bif.str_rdy), 64'd1);
    tick();
    b7_cyc      = cyc;
    b7_pend     = 1'b1;
    bif.str_vld = 1'b0;
    bif.bus_rdy = 1'b0;
    @(negedge clk);
    chk("stall_cnt_wrap", 64'(dut.cnt_q), 64'd0);
    tick();
    bif.bus_rdy = 1'b1;
    tick();
    tick();
    chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stream gaps: valid pattern 1,0,0 with garbage on the data lines.
    t0 = trn_cnt;
    s0 = stall_cnt;
    send_pkt(32'h0F1E2D3C, 32'h4B5A6978, 2);
    tick();
    chk("gap_trn_cnt", 64'(trn_cnt - t0), 64'd1);
    chk("gap_no_stall", 64'(stall_cnt - s0), 64'd0);

    // Reset in the middle of a packet.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_str_rdy", 64'(bif.str_rdy), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_bus_vld", 64'(bif.bus_vld), 64'd0);
    chk("midrst_bus_adr", 64'(bif.bus_adr), 64'd0);
    chk("midrst_bus_dat", 64'(bif.bus_dat), 64'd0);
    chk("midrst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("midrst_str_rdy_after", 64'(bif.str_rdy), 64'd1);
    tick();
    send_pkt(32'h55667788, 32'h99AABBCC, 0);
    tick();
    tick();
    chk("midrst_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset while a packet is stalled on the bus.
    bif.bus_rdy = 1'b0;
    send_pkt(32'h13579BDF, 32'h2468ACE0, 0);
    @(negedge clk);
    chk("stallrst_pending", 64'(bif.bus_vld), 64'd1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("stallrst_bus_vld", 64'(bif.bus_vld), 64'd0);
    chk("stallrst_cnt", 64'(dut.cnt_q), 64'd0);
    bif.bus_rdy = 1'b1;
    tick();
    tick();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
